// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default frame geometry and
// counter width helpers used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int NB_DATA_DEF = 8;
  localparam int N_TICKS_DEF = 16;
  localparam int SB_TICK_DEF = 16;

  // The tick counter must cover whichever of the bit and stop periods is longer.
  function automatic int tick_cnt_w(input int n_ticks, input int sb_tick);
    return $clog2((n_ticks > sb_tick) ? n_ticks : sb_tick);
  endfunction

  function automatic int bit_cnt_w(input int nb_data);
    return (nb_data > 1) ? $clog2(nb_data) : 1;
  endfunction

  localparam int TICK_CNT_W = tick_cnt_w(N_TICKS_DEF, SB_TICK_DEF);
  localparam int BIT_CNT_W  = bit_cnt_w(NB_DATA_DEF);

endpackage

// File: rtl/transmitter.sv
// UART transmitter: start bit, NB_DATA bits LSB-first, stop period, paced by a
// shared 16x oversampling tick, with a one-byte holding register for back-to-back frames.
module transmitter
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int N_TICKS = N_TICKS_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_tx_busy,
  output logic               o_tx_ready
);

  localparam int TICK_W = tick_cnt_w(N_TICKS, SB_TICK);
  localparam int BIT_W  = bit_cnt_w(NB_DATA);

  uart_state_e        state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0] shifter_q, shifter_d;
  logic [NB_DATA-1:0] hold_q, hold_d;
  logic               hold_valid_q, hold_valid_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               bit_last, stop_last;

  assign bit_last  = i_tick && (tick_cnt_q == TICK_W'(N_TICKS - 1));
  assign stop_last = i_tick && (tick_cnt_q == TICK_W'(SB_TICK - 1));

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shifter_d    = shifter_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;

    // A request arriving mid-frame is parked in the holding register.
    if (state_q != IDLE && !hold_valid_q && i_tx_start) begin
      hold_d       = i_tx_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_tx_start && !hold_valid_q) begin
          shifter_d  = i_tx_data;
          tick_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_last) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          tick_cnt_d = '0;
          shifter_d  = shifter_q >> 1;
          if (bit_cnt_q == BIT_W'(NB_DATA - 1)) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      STOP: begin
        if (stop_last) begin
          done_d     = 1'b1;
          tick_cnt_d = '0;
          if (hold_valid_q) begin
            shifter_d    = hold_q;
            hold_valid_d = 1'b0;
            state_d      = START;
          end else if (i_tx_start) begin
            // Same-cycle request goes straight to the shifter, not the hold.
            shifter_d    = i_tx_data;
            hold_valid_d = 1'b0;
            state_d      = START;
          end else begin
            state_d = IDLE;
          end
        end else if (i_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shifter_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shifter_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shifter_q    <= shifter_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      done_q       <= done_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_tx_done  = done_q;
  assign o_tx_busy  = (state_q != IDLE);
  assign o_tx_ready = !hold_valid_q;

endmodule

// File: doc/transmitter.md
Name: transmitter

Overview:
UART serial transmitter, the transmit-side counterpart of the receiver, sharing the same baud_rate_generator tick (16x oversampling).
- Accepts parallel bytes from interface_alu, which sends the ALU result.
- Serializes each byte LSB-first as 1 start bit, NB_DATA data bits, then a stop period.
- Has a one-entry holding register, so a second byte can be queued during a frame and sent back-to-back with no idle gap.

Parameters:
NB_DATA, 8, data bits per frame
N_TICKS, 16, i_tick pulses per start/data bit
SB_TICK, 16, i_tick pulses in stop period (16 = 1 stop bit, 32 = 2)

Ports:
i_clock  input  1  system clock
i_reset  input  1  asynchronous reset, active-low (0 = reset)
i_tick  input  1  1-cycle pulse from baud_rate_generator, every 326 clocks
i_tx_start  input  1  1-cycle request to send i_tx_data
i_tx_data  input  NB_DATA  byte to send, sampled when i_tx_start=1 and o_tx_ready=1
o_tx  output  1  serial line, idle high, registered
o_tx_done  output  1  1-cycle pulse at end of each frame's stop period
o_tx_busy  output  1  1 while state != IDLE
o_tx_ready  output  1  1 when holding register empty (request will be accepted)

Behaviour:
- Reset (i_reset=0, async):
  - o_tx=1, o_tx_done=0, o_tx_busy=0, o_tx_ready=1.
  - state=IDLE; tick counter, bit counter, shifter and hold_valid cleared.
  - Reset mid-frame drives the line high immediately and abandons the frame; no o_tx_done is issued.
- States: IDLE, START, DATA, STOP. Encoding comes from the package.
- Request handling:
  - IDLE, hold empty, i_tx_start=1: shifter<=i_tx_data, tick_cnt<=0, state->START. o_tx=0 from the next clock edge.
  - Non-IDLE, hold empty, i_tx_start=1: hold<=i_tx_data, hold_valid<=1, so o_tx_ready=0 on the next cycle.
  - hold_valid=1 (o_tx_ready=0): i_tx_start is ignored and the byte is dropped. No error flag is raised.
- Bit timing:
  - tick_cnt increments only on i_tick and is cleared on every state or bit transition.
  - START: o_tx=0. On the i_tick where tick_cnt==N_TICKS-1, go to DATA with bit_cnt=0.
  - DATA: o_tx=shifter[0]. On the i_tick where tick_cnt==N_TICKS-1, shift right.
    - If bit_cnt==NB_DATA-1, go to STOP; otherwise bit_cnt++.
  - STOP: o_tx=1. On the i_tick where tick_cnt==SB_TICK-1:
    - o_tx_done=1 for exactly that one cycle;
    - if hold_valid: shifter<=hold, hold_valid<=0, go directly to START (o_tx=0 next cycle, no idle gap);
    - else if i_tx_start=1 in this same cycle: load the shifter directly from i_tx_data and go to START;
    - else go to IDLE.
- The start bit lasts N_TICKS ticks counted from acceptance. The first tick period may be partial because the tick phase is free-running; this is acceptable since the receiver resynchronises on the start edge.
- Nominal frame length: (1+NB_DATA)*N_TICKS + SB_TICK ticks. With defaults this is 160 ticks = 52160 clocks.
- i_tx_data is only sampled at acceptance. Later changes on i_tx_data do not affect the frame in flight or the queued byte.
- o_tx_busy=1 from the cycle after acceptance until the cycle after the final STOP tick, when state returns to IDLE.
- o_tx_ready depends only on hold_valid.

Decomposition:
- Shared package uart_pkg:
  - state encoding (IDLE/START/DATA/STOP), also reused by the receiver;
  - NB_DATA, N_TICKS and SB_TICK defaults;
  - tick counter width (clog2 of the larger of N_TICKS and SB_TICK) and bit counter width.
- No sub-module: the counters, shifter and holding register are inline.
- baud_rate_generator is instantiated at top level and its tick is shared with the receiver.

Test Plan:
- Reset held low for 5 clocks, then released -> o_tx=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0. No activity without a request.
- Single byte 0xAA from IDLE:
  - o_tx sequence: 0, then 0,1,0,1,0,1,0,1 (LSB first), then 1;
  - each bit lasts 16 ticks (5216 clocks, ±326 on the start bit);
  - o_tx_done pulses exactly once, 160 ticks after acceptance.
- Back-to-back 0x0F then 0x24, second request issued during the DATA state of the first:
  - o_tx_ready=0 until the first stop ends;
  - the second start bit begins the cycle after the first o_tx_done, with no idle gap;
  - o_tx_done pulses twice.
- Third request 0xFF while hold is full -> ignored. Only 0x0F and 0x24 appear on o_tx.
- Async reset asserted during bit 3 of 0x55 -> o_tx=1 within the same cycle, state=IDLE. After release, a new 0x3C is transmitted cleanly.
- Loopback o_tx to receiver i_rx, sending 0xAA, 0x0F, 0x24 -> receiver o_rx_data matches each byte, and o_rx_done fires once per frame.
